// File: rtl/ad7606_ctrl.sv
// rtl/ad7606_ctrl.sv - AD7606 parallel-bus conversion/readout controller
// Optional busy watchdog enabled by defining AD7606_TIMEOUT_EN.
module ad7606_ctrl #(
    parameter int CLK_FREQUENCY  = 30_000_000,
    parameter int CHANNELS       = 8,
    parameter int DATA_W         = 16,
    parameter int POWER_ON_TICKS = CLK_FREQUENCY / 1000 * 30,
    parameter int RESET_TICKS    = 2,
    parameter int SETTLE_TICKS   = 1,
    parameter int CONVST_TICKS   = 1,
    parameter int RD_TICKS       = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              power,
    input  logic              start,
    output logic              ready,
    output logic              stby,
    output logic              adc_reset,
    output logic              convst,
    input  logic              busy,
    output logic              cs_n,
    output logic              rd_n,
    input  logic [DATA_W-1:0] db,
    output logic              sample_valid,
    output logic [DATA_W-1:0] sample_data,
    output logic [2:0]        sample_ch,
    output logic              error
);
    localparam int TIMEOUT_TICKS = 1024;
    localparam int M1    = (POWER_ON_TICKS > TIMEOUT_TICKS) ? POWER_ON_TICKS : TIMEOUT_TICKS;
    localparam int M2    = (RESET_TICKS > SETTLE_TICKS) ? RESET_TICKS : SETTLE_TICKS;
    localparam int M3    = (CONVST_TICKS > RD_TICKS) ? CONVST_TICKS : RD_TICKS;
    localparam int M23   = (M2 > M3) ? M2 : M3;
    localparam int MAX_T = (M1 > M23) ? M1 : M23;
    localparam int CNT_W = $clog2(MAX_T + 1);
    localparam logic [2:0] CH_LAST = 3'(CHANNELS - 1);

    typedef enum logic [3:0] {
        S_OFF, S_POWERUP, S_RESET, S_SETTLE, S_IDLE,
        S_CONVST, S_WAIT_BUSY_HI, S_WAIT_BUSY_LO, S_RD_LO, S_RD_HI
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         ch;
    logic               capture;
    logic               power_s1, power_s2, power_d, busy_s1, busy_s2;
    logic [1:0]         sync_fill;
    logic               armed;
    logic               power_rise, power_fall;
`ifdef AD7606_TIMEOUT_EN
    logic               timed_out;
`endif

    // armed only after the synchroniser has refilled and seen power low,
    // so a level that was already high across reset does not count as an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            power_s1  <= 1'b0;
            power_s2  <= 1'b0;
            power_d   <= 1'b0;
            busy_s1   <= 1'b0;
            busy_s2   <= 1'b0;
            sync_fill <= 2'd0;
            armed     <= 1'b0;
        end else begin
            power_s1  <= power;
            power_s2  <= power_s1;
            power_d   <= power_s2;
            busy_s1   <= busy;
            busy_s2   <= busy_s1;
            sync_fill <= (sync_fill == 2'd2) ? 2'd2 : sync_fill + 2'd1;
            armed     <= armed | ((sync_fill == 2'd2) && !power_s2);
        end
    end

    assign power_rise = armed & power_s2 & ~power_d;
    assign power_fall = ~power_s2 & power_d;

    always_comb begin
        state_next = state;
        capture    = 1'b0;
`ifdef AD7606_TIMEOUT_EN
        timed_out  = 1'b0;
`endif
        case (state)
            S_OFF:          if (power_rise) state_next = S_POWERUP;
            S_POWERUP:      if (cnt == CNT_W'(POWER_ON_TICKS - 1)) state_next = S_RESET;
            S_RESET:        if (cnt == CNT_W'(RESET_TICKS - 1)) state_next = S_SETTLE;
            S_SETTLE:       if (cnt == CNT_W'(SETTLE_TICKS - 1)) state_next = S_IDLE;
            S_IDLE:         if (start) state_next = S_CONVST;
            S_CONVST:       if (cnt == CNT_W'(CONVST_TICKS - 1)) state_next = S_WAIT_BUSY_HI;
            S_WAIT_BUSY_HI: if (busy_s2) state_next = S_WAIT_BUSY_LO;
            S_WAIT_BUSY_LO: if (!busy_s2) state_next = S_RD_LO;
            S_RD_LO: begin
                if (cnt == CNT_W'(RD_TICKS - 1)) begin
                    capture    = 1'b1;
                    state_next = S_RD_HI;
                end
            end
            S_RD_HI: begin
                if (cnt == CNT_W'(RD_TICKS - 1))
                    state_next = (ch == CH_LAST) ? S_IDLE : S_RD_LO;
            end
            default:        state_next = S_OFF;
        endcase
`ifdef AD7606_TIMEOUT_EN
        if ((state == S_WAIT_BUSY_HI || state == S_WAIT_BUSY_LO) &&
            cnt == CNT_W'(TIMEOUT_TICKS - 1) && state_next != S_RD_LO) begin
            state_next = S_IDLE;
            timed_out  = 1'b1;
        end
`endif
        if (power_fall) begin
            state_next = S_OFF;
            capture    = 1'b0;
`ifdef AD7606_TIMEOUT_EN
            timed_out  = 1'b0;
`endif
        end
    end

    // outputs are registered from the next state so the ADC pins never glitch
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_OFF;
            cnt          <= '0;
            ch           <= 3'd0;
            stby         <= 1'b0;
            adc_reset    <= 1'b0;
            convst       <= 1'b1;
            cs_n         <= 1'b1;
            rd_n         <= 1'b1;
            ready        <= 1'b0;
            sample_valid <= 1'b0;
            sample_data  <= '0;
            sample_ch    <= 3'd0;
        end else begin
            state <= state_next;
            // the busy-wait budget spans both wait states, so HI->LO keeps counting
            if (state_next != state && !(state == S_WAIT_BUSY_HI && state_next == S_WAIT_BUSY_LO))
                cnt <= '0;
            else if (state == S_OFF || state == S_IDLE)
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);
            if (state == S_WAIT_BUSY_LO && state_next == S_RD_LO)
                ch <= 3'd0;
            else if (state == S_RD_HI && state_next == S_RD_LO)
                ch <= ch + 3'd1;
            sample_valid <= capture;
            if (capture) begin
                sample_data <= db;
                sample_ch   <= ch;
            end
            stby      <= (state_next != S_OFF);
            adc_reset <= (state_next == S_RESET);
            convst    <= (state_next != S_CONVST);
            cs_n      <= !(state_next == S_RD_LO || state_next == S_RD_HI);
            rd_n      <= (state_next != S_RD_LO);
            ready     <= (state_next == S_IDLE);
        end
    end

`ifdef AD7606_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst)
            error <= 1'b0;
        else if (timed_out)
            error <= 1'b1;
        else if (state == S_IDLE && state_next == S_CONVST)
            error <= 1'b0;
    end
`else
    assign error = 1'b0;
`endif
endmodule

// File: tb/tb_ad7606_ctrl.sv
// tb/tb_ad7606_ctrl.sv - directed bench for ad7606_ctrl (8-channel and 1-channel instances)
module tb_ad7606_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        power0 = 1'b0, start0 = 1'b0, busy0 = 1'b0;
    logic [15:0] db0 = 16'h0;
    logic        ready0, stby0, adc_reset0, convst0, cs_n0, rd_n0, sample_valid0, error0;
    logic [15:0] sample_data0;
    logic [2:0]  sample_ch0;
    logic        power1 = 1'b0, start1 = 1'b0, busy1 = 1'b0;
    logic [15:0] db1 = 16'h0;
    logic        ready1, stby1, adc_reset1, convst1, cs_n1, rd_n1, sample_valid1, error1;
    logic [15:0] sample_data1;
    logic [2:0]  sample_ch1;

    int checks = 0;
    int failures = 0;
    int got_n, convst_lows, nrd;
    int drop_at = -1;
    logic [2:0]  got_ch[8];
    logic [15:0] got_data[8];

    always #5 clk = ~clk;

    ad7606_ctrl #(.CHANNELS(8), .DATA_W(16), .POWER_ON_TICKS(30)) dut0 (
        .clk(clk), .rst(rst), .power(power0), .start(start0), .ready(ready0),
        .stby(stby0), .adc_reset(adc_reset0), .convst(convst0), .busy(busy0),
        .cs_n(cs_n0), .rd_n(rd_n0), .db(db0), .sample_valid(sample_valid0),
        .sample_data(sample_data0), .sample_ch(sample_ch0), .error(error0));

    ad7606_ctrl #(.CHANNELS(1), .DATA_W(16), .POWER_ON_TICKS(30)) dut1 (
        .clk(clk), .rst(rst), .power(power1), .start(start1), .ready(ready1),
        .stby(stby1), .adc_reset(adc_reset1), .convst(convst1), .busy(busy1),
        .cs_n(cs_n1), .rd_n(rd_n1), .db(db1), .sample_valid(sample_valid1),
        .sample_data(sample_data1), .sample_ch(sample_ch1), .error(error1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one clock of dut0 with an ADC data model: db = 0x1000 + channel while rd_n is low
    task automatic step();
        tick();
        if (sample_valid0) begin
            if (got_n < 8) begin
                got_ch[got_n]   = sample_ch0;
                got_data[got_n] = sample_data0;
            end
            got_n++;
        end
        if (!convst0) convst_lows++;
        if (!cs_n0 && !rd_n0) begin
            db0 = 16'h1000 + 16'(nrd);
            nrd++;
            if (nrd == drop_at + 1) power0 = 1'b0;
        end
    endtask

    task automatic run_conv(input int hi_cycles, output bit done);
        got_n = 0; convst_lows = 0; nrd = 0; done = 1'b0;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        repeat (2) step();
        for (int i = 0; i < hi_cycles; i++) begin
            busy0  = 1'b1;
            start0 = (i >= 5 && i < 8);
            step();
        end
        start0 = 1'b0;
        busy0  = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            step();
            if (ready0 || !stby0) done = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; power0 = 1'b1; power1 = 1'b1;
        repeat (3) tick();
        checks++;
        if ({stby0, adc_reset0, convst0, cs_n0, rd_n0, ready0, sample_valid0, error0} !== 8'b0011_1000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 00111000",
                     {stby0, adc_reset0, convst0, cs_n0, rd_n0, ready0, sample_valid0, error0});
        end
        checks++;
        if ({sample_data0, sample_ch0} !== 19'h0) begin
            failures++;
            $display("FAIL reset_sample: got %h/%0d expected 0/0", sample_data0, sample_ch0);
        end
        rst = 1'b0;
        repeat (10) tick();
        checks++;
        if (stby0 !== 1'b0 || stby1 !== 1'b0) begin
            failures++;
            $display("FAIL power_high_through_reset: got stby %b%b expected 00", stby0, stby1);
        end
        power0 = 1'b0; power1 = 1'b0;
        repeat (5) tick();
    endtask

    task automatic test_powerup();
        int n, m, lows;
        power0 = 1'b1; power1 = 1'b1;
        tick();
        checks++;
        if (stby0 !== 1'b0) begin
            failures++;
            $display("FAIL stby_early: got %b expected 0", stby0);
        end
        tick(); tick();
        checks++;
        if (stby0 !== 1'b1 || adc_reset0 !== 1'b0) begin
            failures++;
            $display("FAIL stby_rise: got stby=%b adc_reset=%b expected 1 0", stby0, adc_reset0);
        end
        n = 0; lows = 0;
        while (!adc_reset0 && n < 100) begin
            start0 = (n >= 5 && n < 8);
            if (!convst0) lows++;
            n++;
            tick();
        end
        start0 = 1'b0;
        checks++;
        if (n !== 30) begin
            failures++;
            $display("FAIL powerup_cycles: got %0d expected 30", n);
        end
        m = 0;
        while (adc_reset0 && m < 10) begin
            m++;
            tick();
        end
        checks++;
        if (m !== 2) begin
            failures++;
            $display("FAIL adc_reset_width: got %0d expected 2", m);
        end
        checks++;
        if (ready0 !== 1'b0) begin
            failures++;
            $display("FAIL ready_in_settle: got %b expected 0", ready0);
        end
        tick();
        checks++;
        if (ready0 !== 1'b1 || ready1 !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_settle: got %b%b expected 11", ready0, ready1);
        end
        checks++;
        if (lows !== 0) begin
            failures++;
            $display("FAIL start_in_powerup: got %0d convst lows expected 0", lows);
        end
    endtask

    task automatic test_full_conversion();
        bit done;
        run_conv(10, done);
        checks++;
        if (!done || got_n !== 8) begin
            failures++;
            $display("FAIL conv_samples: got done=%0d n=%0d expected 1 8", done, got_n);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got_ch[i] !== 3'(i) || got_data[i] !== 16'h1000 + 16'(i)) begin
                failures++;
                $display("FAIL conv_sample%0d: got ch=%0d data=%h expected ch=%0d data=%h",
                         i, got_ch[i], got_data[i], i, 16'h1000 + 16'(i));
            end
        end
        checks++;
        if (convst_lows !== 1) begin
            failures++;
            $display("FAIL convst_pulses: got %0d low cycles expected 1", convst_lows);
        end
        checks++;
        if (cs_n0 !== 1'b1 || rd_n0 !== 1'b1) begin
            failures++;
            $display("FAIL cs_after_conv: got cs_n=%b rd_n=%b expected 1 1", cs_n0, rd_n0);
        end
    endtask

    task automatic test_single_channel();
        int n = 0;
        logic [2:0]  ch = 3'd7;
        logic [15:0] data = 16'h0;
        db1 = 16'hABCD;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        busy1 = 1'b1;
        repeat (3) tick();
        busy1 = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (sample_valid1) begin
                n++; ch = sample_ch1; data = sample_data1;
            end
            if (ready1) break;
        end
        checks++;
        if (n !== 1 || ch !== 3'd0 || data !== 16'hABCD) begin
            failures++;
            $display("FAIL single_channel: got n=%0d ch=%0d data=%h expected 1 0 abcd", n, ch, data);
        end
        checks++;
        if (ready1 !== 1'b1 || cs_n1 !== 1'b1) begin
            failures++;
            $display("FAIL single_ready: got ready=%b cs_n=%b expected 1 1", ready1, cs_n1);
        end
    endtask

    task automatic test_power_drop();
        bit done;
        int sv = 0, up = 0, w = 0;
        drop_at = 3;
        run_conv(10, done);
        drop_at = -1;
        checks++;
        if (!done || {stby0, cs_n0, rd_n0, convst0, adc_reset0, ready0} !== 6'b011100) begin
            failures++;
            $display("FAIL drop_outputs: got done=%0d %b expected 1 011100", done,
                     {stby0, cs_n0, rd_n0, convst0, adc_reset0, ready0});
        end
        checks++;
        if (got_n < 3 || got_n > 4) begin
            failures++;
            $display("FAIL drop_sample_count: got %0d expected 3..4", got_n);
        end
        repeat (20) begin
            tick();
            if (sample_valid0) sv++;
            if (stby0 || ready0) up++;
        end
        checks++;
        if (sv !== 0 || up !== 0) begin
            failures++;
            $display("FAIL drop_stays_off: got %0d samples %0d active expected 0 0", sv, up);
        end
        power0 = 1'b1;
        while (!ready0 && w < 100) begin
            tick();
            w++;
        end
        checks++;
        if (ready0 !== 1'b1) begin
            failures++;
            $display("FAIL repower_ready: got %b expected 1", ready0);
        end
    endtask

    task automatic test_busy_stuck();
        int n = 0;
        got_n = 0; convst_lows = 0; nrd = 0;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
`ifdef AD7606_TIMEOUT_EN
        while (!ready0 && n < 1200) begin
            step();
            n++;
        end
        checks++;
        if (n !== 1025 || error0 !== 1'b1 || got_n !== 0) begin
            failures++;
            $display("FAIL timeout: got cycles=%0d error=%b n=%0d expected 1025 1 0", n, error0, got_n);
        end
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        checks++;
        if (error0 !== 1'b0) begin
            failures++;
            $display("FAIL error_clear: got %b expected 0", error0);
        end
        n = 0;
        while (!ready0 && n < 1200) begin
            step();
            n++;
        end
`else
        repeat (1100) step();
        checks++;
        if (ready0 !== 1'b0 || error0 !== 1'b0 || got_n !== 0) begin
            failures++;
            $display("FAIL busy_wait: got ready=%b error=%b n=%0d expected 0 0 0", ready0, error0, got_n);
        end
        busy0 = 1'b1;
        repeat (4) step();
        busy0 = 1'b0;
        while (!ready0 && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (ready0 !== 1'b1 || got_n !== 8) begin
            failures++;
            $display("FAIL busy_wait_resume: got ready=%b n=%0d expected 1 8", ready0, got_n);
        end
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_powerup();
        test_full_conversion();
        test_single_channel();
        test_power_drop();
        test_busy_stuck();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ad7606_ctrl.md
AD7606_CTRL -- requirements
Module: ad7606_ctrl

Interface
REQ-001 SHALL provide parameter CLK_FREQUENCY, default 30_000_000, clock frequency in Hz.
REQ-002 SHALL provide parameter CHANNELS, default 8, channels read per conversion, legal range 1..8.
REQ-003 SHALL provide parameter DATA_W, default 16, sample width.
REQ-004 SHALL provide parameter POWER_ON_TICKS, default 30 ms worth of clk cycles derived from CLK_FREQUENCY, standby-exit wait.
REQ-005 SHALL provide parameters RESET_TICKS (default 2), SETTLE_TICKS (default 1), CONVST_TICKS (default 1), RD_TICKS (default 1), all in clk cycles, each >= 1.
REQ-006 SHALL provide ports: clk in 1 system clock; rst in 1 reset, synchronous and active-high.
REQ-007 SHALL provide ports: power in 1 async power request; start in 1 conversion request; ready out 1 idle and able to accept start.
REQ-008 SHALL provide ports: stby out 1; adc_reset out 1; convst out 1; busy in 1 async; cs_n out 1; rd_n out 1; db in DATA_W parallel data bus.
REQ-009 SHALL provide ports: sample_valid out 1; sample_data out DATA_W; sample_ch out 3 channel index; error out 1 (AD7606_TIMEOUT_EN only).

Function
REQ-010 SHALL pass power and busy through 2-flop synchronisers; edges are detected on the synchronised signals.
REQ-011 SHALL implement states OFF, POWERUP, RESET, SETTLE, IDLE, CONVST, WAIT_BUSY_HI, WAIT_BUSY_LO, RD_LO, RD_HI.
REQ-012 SHALL, on a power rising edge in OFF, set stby=1 and enter POWERUP.
REQ-013 SHALL, on a power falling edge in any state, set stby=0, cs_n=1, rd_n=1, convst=1, adc_reset=0, and enter OFF next cycle, aborting any read with no further sample_valid.
REQ-014 SHALL remain in POWERUP exactly POWER_ON_TICKS cycles, then enter RESET.
REQ-015 SHALL hold adc_reset=1 for exactly RESET_TICKS cycles in RESET, then enter SETTLE.
REQ-016 SHALL remain in SETTLE SETTLE_TICKS cycles, then enter IDLE; ready=1 only in IDLE.
REQ-017 SHALL, on start=1 in IDLE, drive convst=0 for CONVST_TICKS cycles, then convst=1 and enter WAIT_BUSY_HI; start outside IDLE is ignored.
REQ-018 SHALL wait for synchronised busy=1, then for synchronised busy=0, then set cs_n=0 and enter RD_LO with channel 0.
REQ-019 SHALL hold rd_n=0 RD_TICKS cycles in RD_LO, capturing db on the last low cycle, then rd_n=1 for RD_TICKS cycles in RD_HI.
REQ-020 SHALL pulse sample_valid for one cycle at RD_LO exit, with sample_data = captured db and sample_ch = current index.
REQ-021 SHALL, after RD_HI for channel CHANNELS-1, set cs_n=1 and return to IDLE; otherwise increment the channel and re-enter RD_LO.
REQ-022 SHALL produce exactly CHANNELS sample_valid pulses per conversion, indices 0..CHANNELS-1 in order, never wrapping.

Reset
REQ-023 SHALL, while rst=1, enter OFF with stby=0, adc_reset=0, convst=1, cs_n=1, rd_n=1, ready=0, sample_valid=0, sample_data=0, sample_ch=0, error=0, counters and synchronisers cleared.
REQ-024 SHALL, with rst=1 and power already high on release, require a fresh power rising edge before leaving OFF.

Configuration
REQ-025 SHALL, when AD7606_TIMEOUT_EN is defined, abort to IDLE with error=1 (sticky until the next accepted start) if WAIT_BUSY_HI plus WAIT_BUSY_LO exceed 1024 cycles, emitting no samples; when undefined, wait indefinitely and tie error to 0.

Verification
REQ-026 SHALL cover power-up: POWER_ON_TICKS=30, power rise -> stby=1 two cycles later, adc_reset high exactly 2 cycles after 30 POWERUP cycles, ready=1 after SETTLE.
REQ-027 SHALL cover full conversion: CHANNELS=8, start, busy high 10 cycles, db=0x1000+ch -> 8 pulses, sample_ch 0..7, sample_data 0x1000..0x1007, cs_n high afterwards.
REQ-028 SHALL cover CHANNELS=1: one pulse with sample_ch=0, then ready=1.
REQ-029 SHALL cover power drop during channel 3 read -> stby=0, cs_n=1 next cycle, no further sample_valid, state OFF.
REQ-030 SHALL cover AD7606_TIMEOUT_EN: busy stuck low after start -> error=1 after 1024 cycles, ready=1, zero samples; error cleared on next start.
REQ-031 SHALL cover start asserted during POWERUP and WAIT_BUSY_LO -> ignored, no extra convst pulse.
